// File: rtl/bid_settle_if.sv
// bid_settle_if: auction-core, host balance-load and result-FIFO signals for the settlement stage
interface bid_settle_if #(parameter int RW = 8);
    logic          roundOver;
    logic          X_win;
    logic          Y_win;
    logic          Z_win;
    logic [31:0]   maxBid;
    logic [1:0]    err;
    logic          bal_load;
    logic [1:0]    bal_sel;
    logic [31:0]   bal_data;
    logic [31:0]   X_balance;
    logic [31:0]   Y_balance;
    logic [31:0]   Z_balance;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_winner;
    logic [1:0]    res_status;
    logic [31:0]   res_amount;
    logic [RW-1:0] res_round;
    logic          busy;
    logic          ovf;
    modport master (
        output roundOver, X_win, Y_win, Z_win, maxBid, err, bal_load, bal_sel, bal_data, res_ready,
        input  X_balance, Y_balance, Z_balance, res_valid, res_winner, res_status, res_amount, res_round, busy, ovf
    );
    modport slave (
        input  roundOver, X_win, Y_win, Z_win, maxBid, err, bal_load, bal_sel, bal_data, res_ready,
        output X_balance, Y_balance, Z_balance, res_valid, res_winner, res_status, res_amount, res_round, busy, ovf
    );
endinterface

// File: rtl/bid_settle.sv
// bid_settle: captures each auction round end, debits the winner's balance
// and queues a {winner, status, amount, round} record for the host
module bid_settle #(
    parameter int DEPTH = 4,
    parameter int RW    = 8
) (
    input logic         clk,
    input logic         reset,
    bid_settle_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int RECW = 36 + RW;
    typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, PUSH} state_t;
    state_t          state_q, state_d;
    logic            ro_q, arm_q;
    logic [2:0]      flags_q, flags_d;
    logic [31:0]     bid_q, bid_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      win_q, win_d;
    logic [1:0]      st_q, st_d;
    logic [31:0]     amt_q, amt_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [31:0]     bal_q [3];
    logic [31:0]     bal_d [3];
    logic            ovf_q, ovf_d;
    logic [RECW-1:0] mem_q [DEPTH];
    logic [RECW-1:0] mem_d [DEPTH];
    logic [AW:0]     wp_q, wp_d, rp_q, rp_d;
    logic            ev, one_hot, valid, full, pop, push;
    logic [1:0]      wi;
    logic [RECW-1:0] head;
    // arm_q masks a roundOver that is already high when reset releases
    assign ev      = bus.roundOver & ~ro_q & arm_q;
    assign one_hot = flags_q == 3'b100 || flags_q == 3'b010 || flags_q == 3'b001;
    assign wi      = win_q - 2'd1;
    assign valid   = wp_q != rp_q;
    assign full    = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign pop     = valid & bus.res_ready;
    assign push    = state_q == PUSH;
    assign head    = mem_q[rp_q[AW-1:0]];
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        bid_d   = bid_q;
        err_d   = err_q;
        win_d   = win_q;
        st_d    = st_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        bal_d   = bal_q;
        ovf_d   = ovf_q;
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        if (state_q != IDLE && ev)
            ovf_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.bal_load && bus.bal_sel != 2'b11)
                    bal_d[bus.bal_sel] = bus.bal_data;
                if (ev) begin
                    flags_d = {bus.Z_win, bus.Y_win, bus.X_win};
                    bid_d   = bus.maxBid;
                    err_d   = bus.err;
                    rnd_d   = cnt_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                win_d   = !(one_hot && err_q == 2'b00) ? 2'b00 : flags_q[0] ? 2'b01 : flags_q[1] ? 2'b10 : 2'b11;
                st_d    = (one_hot && err_q == 2'b00) ? 2'b00 : 2'b01;
                amt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (win_q != 2'b00) begin
                    if (bal_q[wi] >= bid_q) begin
                        bal_d[wi] = bal_q[wi] - bid_q;
                        amt_d     = bid_q;
                    end else
                        st_d = 2'b10;
                end
                state_d = PUSH;
            end
            default: begin
                if (!full || pop) begin
                    mem_d[wp_q[AW-1:0]] = {win_q, st_q, amt_q, rnd_q};
                    wp_d                = wp_q + 1'b1;
                end else
                    ovf_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ro_q    <= 1'b0;
            arm_q   <= 1'b0;
            flags_q <= '0;
            bid_q   <= '0;
            err_q   <= '0;
            win_q   <= '0;
            st_q    <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
            bal_q   <= '{default: '0};
            ovf_q   <= 1'b0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            ro_q    <= bus.roundOver;
            arm_q   <= 1'b1;
            flags_q <= flags_d;
            bid_q   <= bid_d;
            err_q   <= err_d;
            win_q   <= win_d;
            st_q    <= st_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            bal_q   <= bal_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end
    assign bus.X_balance = bal_q[0];
    assign bus.Y_balance = bal_q[1];
    assign bus.Z_balance = bal_q[2];
    assign bus.res_valid = valid;
    assign {bus.res_winner, bus.res_status, bus.res_amount, bus.res_round} = valid ? head : '0;
    assign bus.busy      = state_q != IDLE;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bid_settle.sv
// tb_bid_settle: directed vectors for the settlement stage with hand-computed records and balances
module tb_bid_settle;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    bid_settle_if #(.RW(8)) bus ();
    bid_settle #(.DEPTH(4), .RW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic load(input logic [1:0] sel, input logic [31:0] val);
        bus.bal_load = 1'b1;
        bus.bal_sel  = sel;
        bus.bal_data = val;
        tick(1);
        bus.bal_load = 1'b0;
    endtask
    task automatic round(input logic [2:0] zyx, input logic [31:0] bid, input logic [1:0] e);
        {bus.Z_win, bus.Y_win, bus.X_win} = zyx;
        bus.maxBid    = bid;
        bus.err       = e;
        bus.roundOver = 1'b1;
        tick(1);
        bus.roundOver = 1'b0;
        tick(3);
    endtask
    task automatic pop_rec(input string tag, input logic [1:0] w, input logic [1:0] s, input logic [31:0] a, input logic [7:0] r);
        check({tag, ".valid"}, 64'(bus.res_valid), 64'd1);
        check({tag, ".rec"}, {bus.res_winner, bus.res_status, bus.res_amount, bus.res_round}, {w, s, a, r});
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask
    initial begin
        bus.roundOver = 1'b0;
        {bus.X_win, bus.Y_win, bus.Z_win} = 3'b000;
        bus.maxBid    = '0;
        bus.err       = '0;
        bus.bal_load  = 1'b0;
        bus.bal_sel   = '0;
        bus.bal_data  = '0;
        bus.res_ready = 1'b0;
        do_reset();
        check("rst.X", 64'(bus.X_balance), 64'd0);
        check("rst.valid", 64'(bus.res_valid), 64'd0);
        check("rst.rec", {bus.res_winner, bus.res_status, bus.res_amount, bus.res_round}, 64'd0);
        check("rst.busy_ovf", {bus.busy, bus.ovf}, 64'd0);
        load(2'b00, 32'd100);
        bus.X_win     = 1'b1;
        bus.maxBid    = 32'd40;
        bus.roundOver = 1'b1;
        tick(1);
        bus.roundOver = 1'b0;
        check("t1.busy", 64'(bus.busy), 64'd1);
        tick(1);
        check("t1.bal_early", 64'(bus.X_balance), 64'd100);
        tick(1);
        check("t1.bal_k2", 64'(bus.X_balance), 64'd60);
        check("t1.valid_k2", 64'(bus.res_valid), 64'd0);
        tick(1);
        pop_rec("t1", 2'b01, 2'b00, 32'd40, 8'd0);
        check("t1.empty", 64'(bus.res_valid), 64'd0);
        load(2'b01, 32'd10);
        round(3'b010, 32'd25, 2'b00);
        check("t2.Y", 64'(bus.Y_balance), 64'd10);
        pop_rec("t2", 2'b10, 2'b10, 32'd0, 8'd1);
        round(3'b001, 32'd5, 2'b01);
        pop_rec("t3.err", 2'b00, 2'b01, 32'd0, 8'd2);
        round(3'b101, 32'd5, 2'b00);
        pop_rec("t3.multi", 2'b00, 2'b01, 32'd0, 8'd3);
        check("t3.bal", {bus.X_balance, bus.Z_balance}, {32'd60, 32'd0});
        round(3'b001, 32'd0, 2'b00);
        pop_rec("t3.zero", 2'b01, 2'b00, 32'd0, 8'd4);
        load(2'b11, 32'd999);
        check("t3.sel11", {bus.X_balance, bus.Z_balance}, {32'd60, 32'd0});
        for (int i = 0; i < 5; i++) begin
            round(3'b001, 32'd1, 2'b00);
            tick(1);
        end
        check("t4.ovf", 64'(bus.ovf), 64'd1);
        check("t4.X", 64'(bus.X_balance), 64'd55);
        for (int i = 0; i < 4; i++)
            pop_rec($sformatf("t4.pop%0d", i), 2'b01, 2'b00, 32'd1, 8'(5 + i));
        check("t4.empty", 64'(bus.res_valid), 64'd0);
        do_reset();
        check("t5.ovf_clr", 64'(bus.ovf), 64'd0);
        bus.X_win     = 1'b1;
        bus.maxBid    = 32'd0;
        bus.roundOver = 1'b1;
        tick(1);
        bus.roundOver = 1'b0;
        tick(1);
        bus.roundOver = 1'b1;
        bus.bal_load  = 1'b1;
        bus.bal_sel   = 2'b10;
        bus.bal_data  = 32'd7;
        tick(1);
        bus.roundOver = 1'b0;
        bus.bal_load  = 1'b0;
        tick(5);
        check("t5.ovf", 64'(bus.ovf), 64'd1);
        check("t5.Z", 64'(bus.Z_balance), 64'd0);
        pop_rec("t5", 2'b01, 2'b00, 32'd0, 8'd0);
        check("t5.one", {bus.res_valid, bus.busy}, 64'd0);
        load(2'b00, 32'd50);
        bus.maxBid    = 32'd20;
        bus.roundOver = 1'b1;
        tick(1);
        bus.roundOver = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        check("t6.async", 64'(bus.X_balance), 64'd0);
        tick(2);
        bus.roundOver = 1'b1;
        reset = 1'b0;
        tick(5);
        check("t6.state", {bus.X_balance, bus.res_valid, bus.ovf, bus.busy}, 64'd0);
        bus.roundOver = 1'b0;
        tick(1);
        round(3'b001, 32'd0, 2'b00);
        pop_rec("t6", 2'b01, 2'b00, 32'd0, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
